seg7_scan_capture: RTL and testbench
====================================

# seg7_scan_capture

Receive-side counterpart of the 7-segment decoder. Monitors a multiplexed 4-digit display bus (segment lines plus one-hot digit strobes) and filters out scan-transition ghosting. Reverse-decodes each stable segment pattern back to its 4-bit hex value and holds the reconstructed digits for self-checking benches and board-level readback.

## Interface
- STABLE_CYCLES, 4: consecutive cycles a {an,seg} pair must stay unchanged before capture; legal 1..255.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- seg  in  7  segment lines, active-high, seg[6:0] = {a,b,c,d,e,f,g}
- an  in  4  digit strobes, active-high; an[i] selects digit i
- hex  out  16  reconstructed digits, hex[4i+3:4i] = digit i
- dvalid  out  4  dvalid[i]=1: hex digit i holds a decoded value
- upd  out  1  one-cycle pulse: a digit register was written
- bad_pat  out  1  one-cycle pulse: captured pattern is not a legal glyph
- bad_an  out  1  one-cycle pulse: stable an is not one-hot and not zero
- frame  out  1  one-cycle pulse: all 4 digits captured valid since last frame

## Operation
- Glyph table (seg hex → value): 7E→0, 30→1, 6D→2, 79→3, 33→4, 5B→5, 5F→6, 70→7, 7F→8, 7B→9, 77→A, 1F→B, 4E→C, 3D→D, 4F→E, 47→F. seg=00 is "blank". Any other pattern is illegal.
- Sample register p <= {an,seg} every cycle.
- Stability counter cnt (8 bits) and armed flag:
  - If the input pair differs from p: cnt <= 1, armed <= 1.
  - Else, if cnt < STABLE_CYCLES: cnt <= cnt+1.
- Capture fires when armed and cnt == STABLE_CYCLES. On capture, armed <= 0, so each steady pair is captured once. The captured value is p.
- Capture actions:
  - an == 0000: no action.
  - an not one-hot: bad_an pulse; no register change.
  - an one-hot (digit i), legal glyph: hex digit i <= value, dvalid[i] <= 1, upd pulse, seen[i] <= 1.
  - an one-hot, blank: dvalid[i] <= 0, hex digit i held, upd pulse, no error, seen unchanged.
  - an one-hot, illegal: dvalid[i] <= 0, hex digit i held, bad_pat pulse, no upd, seen unchanged.
- Frame tracking:
  - When a legal capture makes seen == 1111, frame pulses in the same cycle as upd, and seen <= 0000.
  - Re-capturing an already-seen digit does not advance frame.
- Reset mid-operation clears everything immediately, including a pending count. No capture occurs until a new pair has been held for the full window.

## Timing
- Reset values: p=0, cnt=0, armed=0, seen=0; outputs hex=0000, dvalid=0000, upd=bad_pat=bad_an=frame=0.
- All outputs are registered. Pulses are exactly one cycle wide.
- Latency: a new pair first sampled at edge k is captured at edge k+STABLE_CYCLES. Outputs are visible after that edge.
- Any change of an or seg inside the window restarts it. A pair held for STABLE_CYCLES−1 edges is never captured.
- An input change on the same edge as a capture: the capture uses the old stable p, and the new pair starts a fresh window.
- STABLE_CYCLES=1: capture on the edge after first sampling. A pair held indefinitely still produces only one capture.

## Test plan
- Reset then steady: assert rst mid-run, release, hold an=0001, seg=5B for 4 cycles → no upd during rst. upd at edge 4 after sampling; hex[3:0]=5, dvalid=0001.
- Ghost filter: an=0010, seg=6D for 3 cycles, then seg=79 held → no capture of 6D. Single upd with hex[7:4]=3, 4 edges after 79 first sampled.
- Full frame: scan digits 0..3 with glyphs 77,1F,4E,3D, 6 cycles each → hex=DCBA, dvalid=1111, 4 upd pulses, frame coincident with the 4th upd only. A second identical sweep gives a second frame.
- Illegal and blank: digit 2 valid 9, then seg=01 held → bad_pat pulse, dvalid[2]=0, hex[11:8] stays 9. Then seg=00 → upd, no bad_pat, dvalid[2]=0.
- Bad strobes: an=0110 held 10 cycles → exactly one bad_an pulse, no upd, hex unchanged. an=0000 → no pulses.
- Parameter corner: STABLE_CYCLES=1, pair toggling every cycle → a capture on every edge after the first. With the pair held 20 cycles → exactly one upd.

Source files
------------

// File: rtl/seg7_scan_capture.sv
// Display-bus monitor for a multiplexed 4-digit 7-segment display.
// Debounces each {an,seg} pair and reverse-decodes glyphs to hex digits.
module seg7_scan_capture #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  seg,
   input  logic [3:0]  an,
   output logic [15:0] hex,
   output logic [3:0]  dvalid,
   output logic        upd,
   output logic        bad_pat,
   output logic        bad_an,
   output logic        frame
);

   localparam logic [7:0] WIN = 8'(STABLE_CYCLES);

   logic [10:0] p_q, p_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        armed_q, armed_d;
   logic [3:0]  seen_q, seen_d;
   logic [15:0] hex_q, hex_d;
   logic [3:0]  dvalid_q, dvalid_d;
   logic        upd_q, upd_d;
   logic        bad_pat_q, bad_pat_d;
   logic        bad_an_q, bad_an_d;
   logic        frame_q, frame_d;

   logic [3:0]  p_an;
   logic [6:0]  p_seg;
   logic        glyph_ok;
   logic [3:0]  glyph_val;
   logic        capture;
   logic [3:0]  seen_nx;

   assign p_an  = p_q[10:7];
   assign p_seg = p_q[6:0];

   always_comb begin
      glyph_ok  = 1'b1;
      glyph_val = 4'h0;
      case (p_seg)
         7'h7E: glyph_val = 4'h0;
         7'h30: glyph_val = 4'h1;
         7'h6D: glyph_val = 4'h2;
         7'h79: glyph_val = 4'h3;
         7'h33: glyph_val = 4'h4;
         7'h5B: glyph_val = 4'h5;
         7'h5F: glyph_val = 4'h6;
         7'h70: glyph_val = 4'h7;
         7'h7F: glyph_val = 4'h8;
         7'h7B: glyph_val = 4'h9;
         7'h77: glyph_val = 4'hA;
         7'h1F: glyph_val = 4'hB;
         7'h4E: glyph_val = 4'hC;
         7'h3D: glyph_val = 4'hD;
         7'h4F: glyph_val = 4'hE;
         7'h47: glyph_val = 4'hF;
         default: glyph_ok = 1'b0;
      endcase
   end

   always_comb begin
      p_d       = {an, seg};
      cnt_d     = cnt_q;
      armed_d   = armed_q;
      seen_d    = seen_q;
      hex_d     = hex_q;
      dvalid_d  = dvalid_q;
      upd_d     = 1'b0;
      bad_pat_d = 1'b0;
      bad_an_d  = 1'b0;
      frame_d   = 1'b0;
      seen_nx   = seen_q | p_an;

      capture = armed_q && (cnt_q == WIN);
      if (capture)
         armed_d = 1'b0;

      // a new pair restarts the window even on a capture edge
      if ({an, seg} != p_q) begin
         cnt_d   = 8'd1;
         armed_d = 1'b1;
      end else if (cnt_q < WIN) begin
         cnt_d = 8'(cnt_q + 8'd1);
      end

      if (capture && (p_an != 4'b0000)) begin
         if (!$onehot(p_an)) begin
            bad_an_d = 1'b1;
         end else if (glyph_ok) begin
            for (int i = 0; i < 4; i++)
               if (p_an[i])
                  hex_d[4*i +: 4] = glyph_val;
            dvalid_d = dvalid_q | p_an;
            upd_d    = 1'b1;
            if (seen_nx == 4'b1111) begin
               frame_d = 1'b1;
               seen_d  = 4'b0000;
            end else begin
               seen_d = seen_nx;
            end
         end else if (p_seg == 7'h00) begin
            dvalid_d = dvalid_q & ~p_an;
            upd_d    = 1'b1;
         end else begin
            dvalid_d  = dvalid_q & ~p_an;
            bad_pat_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_q       <= '0;
         cnt_q     <= '0;
         armed_q   <= 1'b0;
         seen_q    <= '0;
         hex_q     <= '0;
         dvalid_q  <= '0;
         upd_q     <= 1'b0;
         bad_pat_q <= 1'b0;
         bad_an_q  <= 1'b0;
         frame_q   <= 1'b0;
      end else begin
         p_q       <= p_d;
         cnt_q     <= cnt_d;
         armed_q   <= armed_d;
         seen_q    <= seen_d;
         hex_q     <= hex_d;
         dvalid_q  <= dvalid_d;
         upd_q     <= upd_d;
         bad_pat_q <= bad_pat_d;
         bad_an_q  <= bad_an_d;
         frame_q   <= frame_d;
      end
   end

   assign hex     = hex_q;
   assign dvalid  = dvalid_q;
   assign upd     = upd_q;
   assign bad_pat = bad_pat_q;
   assign bad_an  = bad_an_q;
   assign frame   = frame_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture: a 4-cycle window instance
// and a 1-cycle window instance share clock and reset.
module tb_seg7_scan_capture;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  seg, seg1;
   logic [3:0]  an, an1;
   logic [15:0] hex, hex1;
   logic [3:0]  dvalid, dvalid1;
   logic        upd, bad_pat, bad_an, frame;
   logic        upd1, bad_pat1, bad_an1, frame1;

   int checks = 0;
   int errors = 0;
   int n_upd, n_bad_pat, n_bad_an, n_frame;
   int frame_upd_at, frame_alone, n_upd1;

   logic [6:0] glyph [4] = '{7'h77, 7'h1F, 7'h4E, 7'h3D};

   always #5 clk = ~clk;

   seg7_scan_capture #(.STABLE_CYCLES(4)) u4 (
      .clk(clk), .rst(rst), .seg(seg), .an(an),
      .hex(hex), .dvalid(dvalid), .upd(upd),
      .bad_pat(bad_pat), .bad_an(bad_an), .frame(frame)
   );

   seg7_scan_capture #(.STABLE_CYCLES(1)) u1 (
      .clk(clk), .rst(rst), .seg(seg1), .an(an1),
      .hex(hex1), .dvalid(dvalid1), .upd(upd1),
      .bad_pat(bad_pat1), .bad_an(bad_an1), .frame(frame1)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      n_upd = 0; n_bad_pat = 0; n_bad_an = 0; n_frame = 0;
      frame_upd_at = 0; frame_alone = 0; n_upd1 = 0;
   endtask

   // one edge per iteration, outputs sampled 1 time unit after it
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         n_upd     += int'(upd);
         n_bad_pat += int'(bad_pat);
         n_bad_an  += int'(bad_an);
         n_upd1    += int'(upd1);
         if (frame) begin
            n_frame++;
            frame_upd_at = n_upd;
            if (!upd) frame_alone++;
         end
      end
   endtask

   initial begin
      rst = 1'b1; seg = '0; an = '0; seg1 = '0; an1 = '0;
      clr();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_hex", 32'(hex), 32'h0);
      chk("rst_dvalid", 32'(dvalid), 32'h0);
      chk("rst_pulses", 32'({upd, bad_pat, bad_an, frame}), 32'h0);
      chk("rst_hex1", 32'(hex1), 32'h0);

      // reset asserted mid-window
      rst = 1'b0; an = 4'b0001; seg = 7'h5B;
      tick(2);
      rst = 1'b1;
      tick(2);
      chk("rst_mid_no_upd", 32'(n_upd), 32'd0);
      rst = 1'b0;
      tick(4);
      chk("steady_no_early_upd", 32'(n_upd), 32'd0);
      tick(1);
      chk("steady_upd", 32'(upd), 32'd1);
      chk("steady_hex", 32'(hex), 32'h0005);
      chk("steady_dvalid", 32'(dvalid), 32'h1);
      tick(1);
      chk("steady_upd_width", 32'(upd), 32'd0);

      // ghost glyph held one edge short of the window
      clr();
      an = 4'b0010; seg = 7'h6D;
      tick(3);
      seg = 7'h79;
      tick(4);
      chk("ghost_no_upd", 32'(n_upd), 32'd0);
      tick(1);
      chk("ghost_upd", 32'(upd), 32'd1);
      chk("ghost_hex", 32'(hex), 32'h0035);
      clr();
      tick(5);
      chk("ghost_single", 32'(n_upd), 32'd0);

      // two full sweeps
      for (int s = 0; s < 2; s++) begin
         clr();
         for (int d = 0; d < 4; d++) begin
            an = 4'(1 << d); seg = glyph[d];
            tick(6);
         end
         chk($sformatf("sweep%0d_upd", s), 32'(n_upd), 32'd4);
         chk($sformatf("sweep%0d_frame", s), 32'(n_frame), 32'd1);
         chk($sformatf("sweep%0d_frame_at", s), 32'(frame_upd_at), 32'd4);
         chk($sformatf("sweep%0d_frame_alone", s), 32'(frame_alone), 32'd0);
         chk($sformatf("sweep%0d_hex", s), 32'(hex), 32'hDCBA);
         chk($sformatf("sweep%0d_dvalid", s), 32'(dvalid), 32'hF);
      end

      // illegal then blank on digit 2
      clr();
      an = 4'b0100; seg = 7'h7B;
      tick(6);
      chk("d2_upd", 32'(n_upd), 32'd1);
      chk("d2_hex", 32'(hex), 32'hD9BA);
      clr();
      seg = 7'h01;
      tick(6);
      chk("illegal_bad_pat", 32'(n_bad_pat), 32'd1);
      chk("illegal_no_upd", 32'(n_upd), 32'd0);
      chk("illegal_dvalid", 32'(dvalid), 32'hB);
      chk("illegal_hex", 32'(hex), 32'hD9BA);
      clr();
      seg = 7'h00;
      tick(6);
      chk("blank_upd", 32'(n_upd), 32'd1);
      chk("blank_no_bad", 32'(n_bad_pat), 32'd0);
      chk("blank_dvalid", 32'(dvalid), 32'hB);

      // non-one-hot and idle strobes
      clr();
      an = 4'b0110; seg = 7'h7E;
      tick(10);
      chk("bad_an_once", 32'(n_bad_an), 32'd1);
      chk("bad_an_no_upd", 32'(n_upd), 32'd0);
      chk("bad_an_hex", 32'(hex), 32'hD9BA);
      clr();
      an = 4'b0000;
      tick(10);
      chk("idle_pulses", 32'(n_upd + n_bad_an + n_bad_pat + n_frame), 32'd0);

      // single-cycle window instance
      clr();
      for (int i = 0; i < 10; i++) begin
         an1 = 4'b0001;
         seg1 = (i % 2 == 0) ? 7'h30 : 7'h6D;
         tick(1);
      end
      chk("w1_toggle_upd", 32'(n_upd1), 32'd9);
      clr();
      tick(20);
      chk("w1_hold_upd", 32'(n_upd1), 32'd1);
      chk("w1_hex", 32'(hex1), 32'h0002);
      chk("w1_dvalid", 32'(dvalid1), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
